// File: rtl/vx_gpr_reader.sv
// GPR operand reader: per-warp register banks (two read ports, one masked
// write port) that fetch rs1/rs2 in the accept cycle and, if needed, rs3 one
// cycle later through read port 1. Each read sees a same-cycle writeback to
// the same register and warp, merged lane by lane.
module vx_gpr_reader #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 4,
    localparam int WW         = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int DW         = NUM_THREADS * 32
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [WW-1:0]          req_wid,
    input  logic [4:0]             req_rs1,
    input  logic [4:0]             req_rs2,
    input  logic [4:0]             req_rs3,
    input  logic                   req_use_rs3,

    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DW-1:0]          rsp_rs1_data,
    output logic [DW-1:0]          rsp_rs2_data,
    output logic [DW-1:0]          rsp_rs3_data,

    input  logic                   wb_valid,
    input  logic [WW-1:0]          wb_wid,
    input  logic [4:0]             wb_rd,
    input  logic [NUM_THREADS-1:0] wb_tmask,
    input  logic [DW-1:0]          wb_data
);

    localparam int AW    = WW + 5;
    localparam int DEPTH = NUM_WARPS * 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD3  = 2'd1,
        RSP  = 2'd2
    } state_t;

    // Merge a stored word with a same-cycle writeback to the same register;
    // register 0 always reads as zero.
    function automatic logic [DW-1:0] merge_read(
        input logic [DW-1:0]          stored,
        input logic [WW-1:0]          rd_wid,
        input logic [4:0]             rd_idx,
        input logic                   wr_en,
        input logic [WW-1:0]          wr_wid,
        input logic [4:0]             wr_rd,
        input logic [NUM_THREADS-1:0] wr_mask,
        input logic [DW-1:0]          wr_data
    );
        logic [DW-1:0] result;
        logic          hit;
        hit    = wr_en && (wr_wid == rd_wid) && (wr_rd == rd_idx);
        result = stored;
        for (int i = 0; i < NUM_THREADS; i++) begin
            if (hit && wr_mask[i]) begin
                result[i*32 +: 32] = wr_data[i*32 +: 32];
            end else begin
                result[i*32 +: 32] = stored[i*32 +: 32];
            end
        end
        if (rd_idx == 5'd0) begin
            result = '0;
        end else begin
            result = result;
        end
        return result;
    endfunction

    logic [DW-1:0] mem_r [0:DEPTH-1];

    state_t        state_r;
    state_t        next_s;
    logic [WW-1:0] wid_r;
    logic [4:0]    rs3_r;
    logic [DW-1:0] rs1_data_r;
    logic [DW-1:0] rs2_data_r;
    logic [DW-1:0] rs3_data_r;

    logic          accept_s;
    logic          wr_en_s;
    logic [AW-1:0] wr_addr_s;
    logic [WW-1:0] rd1_wid_s;
    logic [4:0]    rd1_idx_s;
    logic [AW-1:0] rd0_addr_s;
    logic [AW-1:0] rd1_addr_s;
    logic [DW-1:0] rd0_data_s;
    logic [DW-1:0] rd1_data_s;

    // Writebacks are never stalled; writes to x0 and writes during reset are dropped.
    assign wr_en_s   = wb_valid && (wb_rd != 5'd0) && !reset;
    assign wr_addr_s = {wb_wid, wb_rd};
    assign accept_s  = (state_r == IDLE) && req_valid;

    // Read port 1 serves rs1 while idle and the latched rs3 while in RD3.
    always_comb begin
        rd1_wid_s = req_wid;
        rd1_idx_s = req_rs1;
        if (state_r == RD3) begin
            rd1_wid_s = wid_r;
            rd1_idx_s = rs3_r;
        end else begin
            rd1_wid_s = req_wid;
            rd1_idx_s = req_rs1;
        end
    end

    assign rd0_addr_s = {req_wid, req_rs2};
    assign rd1_addr_s = {rd1_wid_s, rd1_idx_s};

    assign rd0_data_s = merge_read(mem_r[rd0_addr_s], req_wid, req_rs2,
                                   wr_en_s, wb_wid, wb_rd, wb_tmask, wb_data);
    assign rd1_data_s = merge_read(mem_r[rd1_addr_s], rd1_wid_s, rd1_idx_s,
                                   wr_en_s, wb_wid, wb_rd, wb_tmask, wb_data);

    // Register file write port: only lanes selected by the thread mask change.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int i = 0; i < NUM_THREADS; i++) begin
                if (wb_tmask[i]) begin
                    mem_r[wr_addr_s][i*32 +: 32] <= wb_data[i*32 +: 32];
                end
            end
        end
    end

    // Next-state logic for the IDLE -> (RD3) -> RSP request sequence.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    next_s = req_use_rs3 ? RD3 : RSP;
                end else begin
                    next_s = IDLE;
                end
            end
            RD3: begin
                next_s = RSP;
            end
            RSP: begin
                if (rsp_ready) begin
                    next_s = IDLE;
                end else begin
                    next_s = RSP;
                end
            end
            default: begin
                next_s = IDLE;
            end
        endcase
    end

    // State and response registers; data is captured only on accept and in
    // RD3 so it stays frozen while the response waits for rsp_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            wid_r      <= '0;
            rs3_r      <= 5'd0;
            rs1_data_r <= '0;
            rs2_data_r <= '0;
            rs3_data_r <= '0;
        end else begin
            state_r <= next_s;
            if (accept_s) begin
                wid_r      <= req_wid;
                rs3_r      <= req_rs3;
                rs1_data_r <= rd1_data_s;
                rs2_data_r <= rd0_data_s;
                rs3_data_r <= '0;
            end else if (state_r == RD3) begin
                rs3_data_r <= rd1_data_s;
            end
        end
    end

    // Outputs come straight from registers, forced inactive while reset is high.
    assign req_ready    = (state_r == IDLE) && !reset;
    assign rsp_valid    = (state_r == RSP) && !reset;
    assign rsp_rs1_data = reset ? '0 : rs1_data_r;
    assign rsp_rs2_data = reset ? '0 : rs2_data_r;
    assign rsp_rs3_data = reset ? '0 : rs3_data_r;

endmodule

// File: doc/vx_gpr_reader.md
VX_GPR_READER -- requirements
Module: VX_gpr_reader

Interface
REQ-001 SHALL provide parameter NUM_WARPS, default 4, number of warps with private register banks.
REQ-002 SHALL provide parameter NUM_THREADS, default 4, lanes per warp; every data word is NUM_THREADS x 32 bits.
REQ-003 SHALL provide port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL provide ports req_valid input 1, req_ready output 1  operand-read request handshake.
REQ-006 SHALL provide ports req_wid input WW, req_rs1/req_rs2/req_rs3 input 5 each, req_use_rs3 input 1  request payload; WW = max(1, clog2(NUM_WARPS)).
REQ-007 SHALL provide ports rsp_valid output 1, rsp_ready input 1  response handshake.
REQ-008 SHALL provide ports rsp_rs1_data/rsp_rs2_data/rsp_rs3_data output NUM_THREADS x 32  operand data, driving the master side of the GPR response interface.
REQ-009 SHALL provide ports wb_valid input 1, wb_wid input WW, wb_rd input 5, wb_tmask input NUM_THREADS, wb_data input NUM_THREADS x 32  writeback port, always accepted.

Function
REQ-010 SHALL hold NUM_WARPS x 32 entries of NUM_THREADS x 32 bits, two read ports, one write port.
REQ-011 SHALL implement FSM states IDLE, RD3, RSP.
REQ-012 SHALL assert req_ready only in IDLE; request accepted in cycle T when req_valid && req_ready.
REQ-013 SHALL, on acceptance in T, register rs1 and rs2 data at end of T; next state RD3 if req_use_rs3 else RSP.
REQ-014 SHALL, in RD3 (cycle T+1), read req_rs3 of the latched wid on read port 1, register at end of T+1, go to RSP.
REQ-015 SHALL assert rsp_valid exactly in RSP: from T+1 without rs3, T+2 with rs3.
REQ-016 SHALL hold all rsp_* data stable while rsp_valid && !rsp_ready; later writebacks do not alter held data.
REQ-017 SHALL, on rsp_valid && rsp_ready, return to IDLE; next request acceptable the following cycle (max throughput one request per 2 cycles, 3 with rs3).
REQ-018 SHALL drive rsp_rs3_data to zero when the request had req_use_rs3 = 0.
REQ-019 SHALL return all-zero data for register index 0 on any port regardless of writes.
REQ-020 SHALL ignore writebacks with wb_rd = 0.
REQ-021 SHALL write wb_data only into lanes with wb_tmask bit set; other lanes keep old value.
REQ-022 SHALL bypass a same-cycle write to the register being read (same wid and index): masked lanes return new wb_data, unmasked lanes old contents.
REQ-023 SHALL apply bypass to rs1, rs2 and rs3 reads independently, including when the same index appears on several ports.
REQ-024 SHALL not stall or drop writebacks in any state.

Reset
REQ-025 SHALL, while reset is high, force state IDLE, rsp_valid 0, req_ready 0, all rsp_* data 0.
REQ-026 SHALL assert req_ready the first cycle after reset deasserts.
REQ-027 SHALL discard any in-flight request or unconsumed response on reset mid-operation; no rsp_valid for it afterwards.
REQ-028 SHALL not clear register-file contents on reset; contents are defined only after written.
REQ-029 SHALL ignore writebacks in reset cycles.

Verification
REQ-030 Write w1 x5 = 0x11111111 all lanes, w1 x6 = 0x22222222; request wid1 rs1=5 rs2=6 use_rs3=0 -> rsp_valid at T+1, rs1 0x11111111, rs2 0x22222222, rs3 0.
REQ-031 Write w2 x7 = 0xA5A5A5A5, request rs1=0 rs2=7 rs3=7 use_rs3=1 -> rsp_valid at T+2, rs1 0, rs2 and rs3 0xA5A5A5A5.
REQ-032 Same-cycle writeback w0 x3 = 0xDEADBEEF tmask 0b0101 over old 0x0 while reading w0 rs1=3 -> lanes 0,2 0xDEADBEEF, lanes 1,3 0x0.
REQ-033 rsp_ready low 5 cycles with writeback to read register meanwhile -> rsp data unchanged, req_ready 0 throughout, IDLE one cycle after handshake.
REQ-034 Writeback to x0 = 0xFFFFFFFF then read rs1=0 -> 0; reset asserted in RD3 -> rsp_valid 0, req_ready 1 cycle after reset release.
